// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM->WB register stage that selects the write-back source,
// optionally extends sub-word loads, and counts committed register writes.
// Optional feature macro: WB_LOAD_EXT_EN (byte/half load select + extension).
// Without it, data-memory words pass through unchanged.
module wb_select_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              stall,
   input  logic              flush,
   input  logic              mwreg,
   input  logic [1:0]        msel,
   input  logic [REG_AW-1:0] mrn,
   input  logic [DATA_W-1:0] malu,
   input  logic [DATA_W-1:0] mmem,
   input  logic [DATA_W-1:0] mlink,
   input  logic [1:0]        mlsize,
   input  logic              munsigned,
   input  logic [1:0]        maddr_lo,
   output logic              wwreg,
   output logic [REG_AW-1:0] wrn,
   output logic [DATA_W-1:0] wdata,
   output logic [CNT_W-1:0]  commit_cnt
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [1:0] LS_HALF  = 2'b01;
   localparam logic [1:0] LS_BYTE  = 2'b10;

   logic              wwreg_q, wwreg_d;
   logic [REG_AW-1:0] wrn_q,   wrn_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [DATA_W-1:0] ld_val;

`ifdef WB_LOAD_EXT_EN
   localparam int unsigned IW = $clog2(DATA_W);

   logic [1:0]  boff;
   logic        hoff;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   // Little-endian byte/half select followed by sign or zero extension
   always_comb begin
      // On a 16-bit datapath only one address bit selects a byte and no half select exists
      boff = maddr_lo & 2'(DATA_W/8 - 1);
      hoff = (DATA_W > 16) ? maddr_lo[1] : 1'b0;
      ld_b = mmem[IW'({boff, 3'b000}) +: 8];
      ld_h = mmem[IW'({hoff, 4'b0000}) +: 16];
      ld_val = mmem;
      case (mlsize)
         LS_HALF: begin
            ld_val       = {DATA_W{ld_h[15] & ~munsigned}};
            ld_val[15:0] = ld_h;
         end
         LS_BYTE: begin
            ld_val      = {DATA_W{ld_b[7] & ~munsigned}};
            ld_val[7:0] = ld_b;
         end
         default: ld_val = mmem;
      endcase
   end
`else
   logic unused_ld_ctrl;

   // Loads are whole words; size/sign/offset controls are don't-care here
   always_comb begin
      ld_val         = mmem;
      unused_ld_ctrl = ^{mlsize, munsigned, maddr_lo};
   end
`endif

   // Next-state: flush beats stall, stall holds, otherwise capture MEM stage
   always_comb begin
      wwreg_d = wwreg_q;
      wrn_d   = wrn_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      if (flush) begin
         wwreg_d = 1'b0;
      end else if (!stall) begin
         wrn_d = mrn;
         case (msel)
            SEL_ALU:  wdata_d = malu;
            SEL_MEM:  wdata_d = ld_val;
            SEL_LINK: wdata_d = mlink;
            default:  wdata_d = '0;
         endcase
         wwreg_d = mwreg && (mrn != '0) && (msel != 2'b11);
         if (wwreg_d) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Stage registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wwreg_q <= 1'b0;
         wrn_q   <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         wwreg_q <= wwreg_d;
         wrn_q   <= wrn_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wwreg      = wwreg_q;
   assign wrn        = wrn_q;
   assign wdata      = wdata_q;
   assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: directed vectors with hand-computed expectations for
// wb_select_stage (default 32-bit instance plus a CNT_W=4 instance for wrap).
module tb_wb_select_stage;

   logic        clk = 1'b0;
   logic        clrn;
   logic        stall, flush, mwreg, munsigned;
   logic [1:0]  msel, mlsize, maddr_lo;
   logic [4:0]  mrn;
   logic [31:0] malu, mmem, mlink;

   logic        wwreg,  wwreg4;
   logic [4:0]  wrn,    wrn4;
   logic [31:0] wdata,  wdata4;
   logic [31:0] commit_cnt;
   logic [3:0]  commit_cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_select_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
      .clk(clk), .clrn(clrn), .stall(stall), .flush(flush), .mwreg(mwreg),
      .msel(msel), .mrn(mrn), .malu(malu), .mmem(mmem), .mlink(mlink),
      .mlsize(mlsize), .munsigned(munsigned), .maddr_lo(maddr_lo),
      .wwreg(wwreg), .wrn(wrn), .wdata(wdata), .commit_cnt(commit_cnt)
   );

   wb_select_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .clrn(clrn), .stall(stall), .flush(flush), .mwreg(mwreg),
      .msel(msel), .mrn(mrn), .malu(malu), .mmem(mmem), .mlink(mlink),
      .mlsize(mlsize), .munsigned(munsigned), .maddr_lo(maddr_lo),
      .wwreg(wwreg4), .wrn(wrn4), .wdata(wdata4), .commit_cnt(commit_cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] rn,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] lnk,
                        input logic [1:0] lsz, input logic uns, input logic [1:0] alo);
      mwreg = we; msel = sel; mrn = rn; malu = alu; mmem = mem; mlink = lnk;
      mlsize = lsz; munsigned = uns; maddr_lo = alo;
   endtask

   initial begin
      clrn = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 2'b00, 5'd0, '0, '0, '0, 2'b00, 1'b0, 2'b00);
      #3;
      chk("rst_wwreg", 64'(wwreg), 64'd0);
      chk("rst_wrn",   64'(wrn),   64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_cnt",   64'(commit_cnt), 64'd0);
      tick();
      clrn = 1'b1;

      // ALU write
      drive(1'b1, 2'b00, 5'd3, 32'h1234_5678, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      chk("alu_wwreg", 64'(wwreg), 64'd1);
      chk("alu_wrn",   64'(wrn),   64'd3);
      chk("alu_wdata", 64'(wdata), 64'h1234_5678);
      chk("alu_cnt",   64'(commit_cnt), 64'd1);

      // Link write
      drive(1'b1, 2'b10, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0000_1004, 2'b00, 1'b0, 2'b00);
      tick();
      chk("link_wrn",   64'(wrn),   64'd31);
      chk("link_wdata", 64'(wdata), 64'h0000_1004);
      chk("link_cnt",   64'(commit_cnt), 64'd2);

      // Data-memory loads
      drive(1'b1, 2'b01, 5'd5, 32'h0, 32'h80FF_7F01, 32'h0, 2'b10, 1'b0, 2'b11);
      tick();
`ifdef WB_LOAD_EXT_EN
      chk("ld_byte_s", 64'(wdata), 64'hFFFF_FF80);
`else
      chk("ld_word_a", 64'(wdata), 64'h80FF_7F01);
`endif
      munsigned = 1'b1;
      tick();
`ifdef WB_LOAD_EXT_EN
      chk("ld_byte_u", 64'(wdata), 64'h0000_0080);
`else
      chk("ld_word_b", 64'(wdata), 64'h80FF_7F01);
`endif
      mlsize = 2'b01; munsigned = 1'b0; maddr_lo = 2'b11;
      tick();
`ifdef WB_LOAD_EXT_EN
      chk("ld_half_s", 64'(wdata), 64'hFFFF_80FF);
`else
      chk("ld_word_c", 64'(wdata), 64'h80FF_7F01);
`endif
      mlsize = 2'b10; maddr_lo = 2'b01;
      tick();
`ifdef WB_LOAD_EXT_EN
      chk("ld_byte_1", 64'(wdata), 64'h0000_007F);
`else
      chk("ld_word_d", 64'(wdata), 64'h80FF_7F01);
`endif
      chk("ld_cnt", 64'(commit_cnt), 64'd6);

      // Stall two cycles with new inputs presented: everything holds
      stall = 1'b1;
      drive(1'b1, 2'b00, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      tick();
      chk("stall_wwreg", 64'(wwreg), 64'd1);
      chk("stall_wrn",   64'(wrn),   64'd5);
`ifdef WB_LOAD_EXT_EN
      chk("stall_wdata", 64'(wdata), 64'h0000_007F);
`else
      chk("stall_wdata", 64'(wdata), 64'h80FF_7F01);
`endif
      chk("stall_cnt",   64'(commit_cnt), 64'd6);

      // Stall plus flush: bubble, counter unchanged
      flush = 1'b1;
      tick();
      chk("flush_wwreg", 64'(wwreg), 64'd0);
      chk("flush_cnt",   64'(commit_cnt), 64'd6);
      stall = 1'b0; flush = 1'b0;

      // Register 0 is never written
      drive(1'b1, 2'b00, 5'd0, 32'hAAAA_AAAA, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      chk("r0_wwreg", 64'(wwreg), 64'd0);
      chk("r0_cnt",   64'(commit_cnt), 64'd6);

      // Reserved select
      drive(1'b1, 2'b11, 5'd4, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 2'b00, 1'b0, 2'b00);
      tick();
      chk("rsv_wwreg", 64'(wwreg), 64'd0);
      chk("rsv_wdata", 64'(wdata), 64'd0);
      chk("rsv_cnt",   64'(commit_cnt), 64'd6);

      // One more commit to reach 7, then reset mid-stall/flush
      drive(1'b1, 2'b00, 5'd9, 32'h0000_0099, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      chk("pre_rst_cnt", 64'(commit_cnt), 64'd7);
      stall = 1'b1; flush = 1'b1;
      clrn = 1'b0;
      #2;
      chk("mid_rst_wwreg", 64'(wwreg), 64'd0);
      chk("mid_rst_wrn",   64'(wrn),   64'd0);
      chk("mid_rst_wdata", 64'(wdata), 64'd0);
      chk("mid_rst_cnt",   64'(commit_cnt), 64'd0);
      tick();
      chk("hold_rst_cnt", 64'(commit_cnt), 64'd0);
      clrn = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 2'b00, 5'd2, 32'h0BAD_F00D, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      chk("post_rst_wdata", 64'(wdata), 64'h0BAD_F00D);
      chk("post_rst_cnt",   64'(commit_cnt), 64'd1);
      chk("post_rst_cnt4",  64'(commit_cnt4), 64'd1);

      // 15 more commits: 4-bit counter wraps 15 -> 0 on the 16th total
      for (int i = 0; i < 14; i++) tick();
      chk("wrap_cnt4_15", 64'(commit_cnt4), 64'd15);
      tick();
      chk("wrap_cnt4_0", 64'(commit_cnt4), 64'd0);
      chk("wrap_cnt32",  64'(commit_cnt),  64'd16);
      mwreg = 1'b0;
      tick();
      chk("nowe_wwreg", 64'(wwreg), 64'd0);
      chk("nowe_cnt4",  64'(commit_cnt4), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
